// File: rtl/general_defs.sv
// Shared pipeline definitions: register address width, memory-read encoding
// and the hazard controller state type.
package general_defs;

    localparam int ADDR_WIDTH = 5;

    typedef enum logic {
        MEM_READ_OFF = 1'b0,
        MEM_READ_ON  = 1'b1
    } mem_read_signal;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    // Count qualifying events, sticking at the maximum value.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_o <= {WIDTH{1'b0}};
        end else if (inc_i && (count_o != CNT_MAX)) begin
            count_o <= count_o + CNT_ONE;
        end else begin
            count_o <= count_o;
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use stall and taken-branch flush control around the decode/execute
// pipeline register, with saturating stall/flush event counters.
module hazard_stall_controller
    import general_defs::*;
#(
    parameter int LOAD_LATENCY = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  dec_valid_i,
    input  logic                  dec_uses_reg_1_i,
    input  logic                  dec_uses_reg_2_i,
    input  logic [ADDR_WIDTH-1:0] dec_reg_1_source_addr_i,
    input  logic [ADDR_WIDTH-1:0] dec_reg_2_source_addr_i,
    input  logic                  ex_is_valid_i,
    input  mem_read_signal        ex_mem_read_en_i,
    input  logic [ADDR_WIDTH-1:0] ex_reg_dest_addr_i,
    input  logic                  branch_taken_i,
    output logic                  stall_o,
    output logic                  bubble_o,
    output logic                  flush_o,
    output logic [CNT_WIDTH-1:0]  stall_count_o,
    output logic [CNT_WIDTH-1:0]  flush_count_o
);

    // Reload values are "remaining cycles after the entry cycle".
    localparam logic [2:0] LOAD_CNT  = 3'(LOAD_LATENCY - 1);
    localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_CYCLES - 1);

    hazard_state_t state_r;
    logic [2:0]    cnt_r;
    logic [2:0]    cnt_dec_s;
    logic          hazard_s;
    logic          src1_hit_s;
    logic          src2_hit_s;
    logic          stall_s;
    logic          bubble_s;
    logic          flush_s;

    assign src1_hit_s = dec_uses_reg_1_i && (dec_reg_1_source_addr_i == ex_reg_dest_addr_i);
    assign src2_hit_s = dec_uses_reg_2_i && (dec_reg_2_source_addr_i == ex_reg_dest_addr_i);
    assign hazard_s   = ex_is_valid_i && (ex_mem_read_en_i == MEM_READ_ON) && dec_valid_i
                        && (src1_hit_s || src2_hit_s);
    assign cnt_dec_s  = cnt_r - 3'd1;

    // Mealy control outputs; reset silences everything immediately.
    always_comb begin
        stall_s  = 1'b0;
        bubble_s = 1'b0;
        flush_s  = 1'b0;
        if (reset_i) begin
            stall_s  = 1'b0;
            bubble_s = 1'b0;
            flush_s  = 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (branch_taken_i) begin
                        flush_s  = 1'b1;
                        bubble_s = 1'b1;
                    end else if (hazard_s) begin
                        stall_s  = 1'b1;
                        bubble_s = 1'b1;
                    end else begin
                        bubble_s = 1'b0;
                    end
                end
                LOAD_STALL: begin
                    if (branch_taken_i) begin
                        flush_s  = 1'b1;
                        bubble_s = 1'b1;
                    end else begin
                        stall_s  = 1'b1;
                        bubble_s = 1'b1;
                    end
                end
                FLUSH: begin
                    flush_s  = 1'b1;
                    bubble_s = 1'b1;
                end
                default: begin
                    stall_s  = 1'b0;
                    bubble_s = 1'b0;
                    flush_s  = 1'b0;
                end
            endcase
        end
    end

    // State and shared down-counter; a taken branch always wins over a stall.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= RUN;
            cnt_r   <= 3'd0;
        end else begin
            case (state_r)
                RUN: begin
                    if (branch_taken_i && (FLUSH_CYCLES > 1)) begin
                        state_r <= FLUSH;
                        cnt_r   <= FLUSH_CNT;
                    end else if (!branch_taken_i && hazard_s && (LOAD_LATENCY > 1)) begin
                        state_r <= LOAD_STALL;
                        cnt_r   <= LOAD_CNT;
                    end else begin
                        state_r <= RUN;
                        cnt_r   <= 3'd0;
                    end
                end
                LOAD_STALL: begin
                    if (branch_taken_i) begin
                        state_r <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                        cnt_r   <= (FLUSH_CYCLES > 1) ? FLUSH_CNT : 3'd0;
                    end else if (cnt_dec_s == 3'd0) begin
                        state_r <= RUN;
                        cnt_r   <= 3'd0;
                    end else begin
                        state_r <= LOAD_STALL;
                        cnt_r   <= cnt_dec_s;
                    end
                end
                FLUSH: begin
                    if (branch_taken_i) begin
                        state_r <= FLUSH;
                        cnt_r   <= FLUSH_CNT;
                    end else if (cnt_dec_s == 3'd0) begin
                        state_r <= RUN;
                        cnt_r   <= 3'd0;
                    end else begin
                        state_r <= FLUSH;
                        cnt_r   <= cnt_dec_s;
                    end
                end
                default: begin
                    state_r <= RUN;
                    cnt_r   <= 3'd0;
                end
            endcase
        end
    end

    assign stall_o  = stall_s;
    assign bubble_o = bubble_s;
    assign flush_o  = flush_s;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (stall_s),
        .count_o (stall_count_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (branch_taken_i && !reset_i),
        .count_o (flush_count_o)
    );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: instance A uses defaults,
// instance B uses LOAD_LATENCY=3 and a 4-bit counter width.
module tb_hazard_stall_controller;
    import general_defs::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset_i;
    logic                  dec_valid;
    logic                  uses1;
    logic                  uses2;
    logic [ADDR_WIDTH-1:0] src1;
    logic [ADDR_WIDTH-1:0] src2;
    logic                  ex_valid;
    mem_read_signal        mem_rd;
    logic [ADDR_WIDTH-1:0] dest;
    logic                  branch;

    logic        a_stall, a_bubble, a_flush;
    logic [15:0] a_scnt, a_fcnt;
    logic        b_stall, b_bubble, b_flush;
    logic [3:0]  b_scnt, b_fcnt;

    hazard_stall_controller #(.LOAD_LATENCY(1), .FLUSH_CYCLES(2), .CNT_WIDTH(16)) dut_a (
        .clk_i(clk), .reset_i(reset_i), .dec_valid_i(dec_valid),
        .dec_uses_reg_1_i(uses1), .dec_uses_reg_2_i(uses2),
        .dec_reg_1_source_addr_i(src1), .dec_reg_2_source_addr_i(src2),
        .ex_is_valid_i(ex_valid), .ex_mem_read_en_i(mem_rd), .ex_reg_dest_addr_i(dest),
        .branch_taken_i(branch), .stall_o(a_stall), .bubble_o(a_bubble), .flush_o(a_flush),
        .stall_count_o(a_scnt), .flush_count_o(a_fcnt)
    );

    hazard_stall_controller #(.LOAD_LATENCY(3), .FLUSH_CYCLES(2), .CNT_WIDTH(4)) dut_b (
        .clk_i(clk), .reset_i(reset_i), .dec_valid_i(dec_valid),
        .dec_uses_reg_1_i(uses1), .dec_uses_reg_2_i(uses2),
        .dec_reg_1_source_addr_i(src1), .dec_reg_2_source_addr_i(src2),
        .ex_is_valid_i(ex_valid), .ex_mem_read_en_i(mem_rd), .ex_reg_dest_addr_i(dest),
        .branch_taken_i(branch), .stall_o(b_stall), .bubble_o(b_bubble), .flush_o(b_flush),
        .stall_count_o(b_scnt), .flush_count_o(b_fcnt)
    );

    typedef struct {
        string       tag;
        logic [2:0]  ctl;   // {stall, bubble, flush}
        logic [15:0] scnt;
        logic [15:0] fcnt;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic set_in(input logic rst, input logic dv, input logic u1, input logic u2,
                          input logic [ADDR_WIDTH-1:0] a1, input logic [ADDR_WIDTH-1:0] a2,
                          input logic exv, input logic mr, input logic [ADDR_WIDTH-1:0] d,
                          input logic br);
        reset_i   = rst;
        dec_valid = dv;
        uses1     = u1;
        uses2     = u2;
        src1      = a1;
        src2      = a2;
        ex_valid  = exv;
        mem_rd    = mr ? MEM_READ_ON : MEM_READ_OFF;
        dest      = d;
        branch    = br;
    endtask

    // Load of r3 in execute, decode reads r3 on source 1.
    task automatic hazard_in(input logic rst, input logic br);
        set_in(rst, 1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 1'b1, 1'b1, 5'd3, br);
    endtask

    task automatic idle_in();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic expect2(input string tag,
                           input logic [2:0] ca, input int sa, input int fa,
                           input logic [2:0] cb, input int sb, input int fb);
        exp_t e;
        e.tag = tag; e.ctl = ca; e.scnt = 16'(sa); e.fcnt = 16'(fa);
        qa.push_back(e);
        e.ctl = cb; e.scnt = 16'(sb); e.fcnt = 16'(fb);
        qb.push_back(e);
    endtask

    task automatic check_step();
        exp_t        e;
        logic [2:0]  obs_ctl;
        logic [31:0] obs_cnt;
        @(negedge clk);
        while (qa.size() > 0) begin
            e = qa.pop_front();
            obs_ctl = {a_stall, a_bubble, a_flush};
            obs_cnt = {a_scnt, a_fcnt};
            total++;
            assert (obs_ctl === e.ctl) else begin
                bad++;
                $error("FAIL %s.a ctl(stall,bubble,flush) got=%b exp=%b", e.tag, obs_ctl, e.ctl);
            end
            total++;
            assert (obs_cnt === {e.scnt, e.fcnt}) else begin
                bad++;
                $error("FAIL %s.a counts got=%0d/%0d exp=%0d/%0d", e.tag, a_scnt, a_fcnt, e.scnt, e.fcnt);
            end
        end
        while (qb.size() > 0) begin
            e = qb.pop_front();
            obs_ctl = {b_stall, b_bubble, b_flush};
            obs_cnt = {12'd0, b_scnt, 12'd0, b_fcnt};
            total++;
            assert (obs_ctl === e.ctl) else begin
                bad++;
                $error("FAIL %s.b ctl(stall,bubble,flush) got=%b exp=%b", e.tag, obs_ctl, e.ctl);
            end
            total++;
            assert (obs_cnt === {e.scnt, e.fcnt}) else begin
                bad++;
                $error("FAIL %s.b counts got=%0d/%0d exp=%0d/%0d", e.tag, b_scnt, b_fcnt, e.scnt, e.fcnt);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        hazard_in(1'b1, 1'b1);
        @(posedge clk);
        #1;

        // Reset holds outputs low even with hazard and branch present.
        hazard_in(1'b1, 1'b1);
        expect2("rst_hold", 3'b000, 0, 0, 3'b000, 0, 0); check_step();
        idle_in();
        expect2("idle", 3'b000, 0, 0, 3'b000, 0, 0); check_step();

        // Load-use on source 1: A stalls one cycle, B three.
        hazard_in(1'b0, 1'b0);
        expect2("lu1_c0", 3'b110, 0, 0, 3'b110, 0, 0); check_step();
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
        expect2("lu1_c1", 3'b000, 1, 0, 3'b110, 1, 0); check_step();
        expect2("lu1_c2", 3'b000, 1, 0, 3'b110, 2, 0); check_step();
        expect2("lu1_c3", 3'b000, 1, 0, 3'b000, 3, 0); check_step();

        // Non-load producer, and unused source 1, must not stall.
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b0);
        expect2("nonload", 3'b000, 1, 0, 3'b000, 3, 0); check_step();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0);
        expect2("unused", 3'b000, 1, 0, 3'b000, 3, 0); check_step();

        // Match on source 2 only.
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0);
        expect2("lu2_c0", 3'b110, 1, 0, 3'b110, 3, 0); check_step();
        idle_in();
        expect2("lu2_c1", 3'b000, 2, 0, 3'b110, 4, 0); check_step();
        expect2("lu2_c2", 3'b000, 2, 0, 3'b110, 5, 0); check_step();

        // Decode bubble never stalls.
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 5'd0, 1'b1, 1'b1, 5'd3, 1'b0);
        expect2("dec_inv", 3'b000, 2, 0, 3'b000, 6, 0); check_step();

        set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        expect2("rst2", 3'b000, 2, 0, 3'b000, 6, 0); check_step();

        // Branch beats hazard; flush held two cycles.
        hazard_in(1'b0, 1'b1);
        expect2("br_c0", 3'b011, 0, 0, 3'b011, 0, 0); check_step();
        hazard_in(1'b0, 1'b0);
        expect2("br_c1", 3'b011, 0, 1, 3'b011, 0, 1); check_step();
        idle_in();
        expect2("br_c2", 3'b000, 0, 1, 3'b000, 0, 1); check_step();

        // Reset in the second cycle of B's three-cycle stall.
        hazard_in(1'b0, 1'b0);
        expect2("rstls_c0", 3'b110, 0, 1, 3'b110, 0, 1); check_step();
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
        expect2("rstls_c1", 3'b000, 1, 1, 3'b000, 1, 1); check_step();
        idle_in();
        expect2("rstls_c2", 3'b000, 0, 0, 3'b000, 0, 0); check_step();

        // Branch during LOAD_STALL, then another branch while flushing.
        hazard_in(1'b0, 1'b0);
        expect2("lsbr_c0", 3'b110, 0, 0, 3'b110, 0, 0); check_step();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        expect2("lsbr_c1", 3'b011, 1, 0, 3'b011, 1, 0); check_step();
        expect2("lsbr_c2", 3'b011, 1, 1, 3'b011, 1, 1); check_step();
        idle_in();
        expect2("lsbr_c3", 3'b011, 1, 2, 3'b011, 1, 2); check_step();
        expect2("lsbr_c4", 3'b000, 1, 2, 3'b000, 1, 2); check_step();

        // Persistent hazard: B's 4-bit stall counter must saturate at 15.
        hazard_in(1'b0, 1'b0);
        for (int i = 0; i < 21; i++) begin
            expect2($sformatf("sat_%0d", i), 3'b110, 1 + i, 2, 3'b110, (1 + i > 15) ? 15 : 1 + i, 2);
            check_step();
        end
        idle_in();
        expect2("sat_end", 3'b000, 22, 2, 3'b000, 15, 2); check_step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Control block on both sides of the decode/execute pipeline register.
- Reads that register's outputs (execute-stage valid, memory-read enable and destination address) and compares them with the source registers of the instruction now in decode.
- Drives the pipeline stall, bubble and flush controls:
  - bubble_o forces the register's is_valid input low;
  - stall_o freezes PC and fetch/decode;
  - flush_o kills fetch/decode after a taken branch.
- Handles load-use hazards and branch flushes, and keeps saturating event counters for performance debug.

Parameters:
LOAD_LATENCY, 1, number of bubble cycles inserted per load-use hazard (1..7)
FLUSH_CYCLES, 2, number of cycles flush_o is held after a taken branch (1..7)
CNT_WIDTH, 16, width of the stall and flush event counters

Ports:
clk_i  input  1  clock
reset_i  input  1  synchronous active-high reset
dec_valid_i  input  1  decode stage holds a real instruction
dec_uses_reg_1_i  input  1  decode instruction reads source 1
dec_uses_reg_2_i  input  1  decode instruction reads source 2
dec_reg_1_source_addr_i  input  ADDR_WIDTH  decode source 1 address
dec_reg_2_source_addr_i  input  ADDR_WIDTH  decode source 2 address
ex_is_valid_i  input  1  is_valid output of the decode/execute register
ex_mem_read_en_i  input  mem_read_signal  memory-read enable of the instruction in execute
ex_reg_dest_addr_i  input  ADDR_WIDTH  destination address of the instruction in execute
branch_taken_i  input  1  execute resolved a taken branch; already qualified by ex_is_valid
stall_o  output  1  hold PC and the fetch/decode register
bubble_o  output  1  force decode/execute is_valid input to 0 this cycle
flush_o  output  1  clear fetch/decode register valid at the next edge
stall_count_o  output  CNT_WIDTH  cycles with stall_o asserted, saturating
flush_count_o  output  CNT_WIDTH  taken-branch flush events, saturating

Behaviour:
- Interface fixed: single clock clk_i; reset_i is synchronous and active-high.
- Outputs stall_o, bubble_o and flush_o are combinational (Mealy) from state and inputs, so a hazard is acted on in the same cycle.
- Counters and state are registered.
- Hazard term:
  - ex_is_valid_i & (ex_mem_read_en_i == read encoding) & dec_valid_i
  - & ((dec_uses_reg_1_i & source 1 address == ex_reg_dest_addr_i) | (dec_uses_reg_2_i & source 2 address == ex_reg_dest_addr_i)).
- FSM states: RUN, LOAD_STALL, FLUSH. A 3-bit down-counter cnt is shared by LOAD_STALL and FLUSH.
- RUN:
  - branch_taken_i → flush_o=1, bubble_o=1, stall_o=0. Go to FLUSH with cnt=FLUSH_CYCLES-1, or stay in RUN if FLUSH_CYCLES==1. Branch beats hazard.
  - else hazard → stall_o=1, bubble_o=1. Go to LOAD_STALL with cnt=LOAD_LATENCY-1, or stay in RUN if LOAD_LATENCY==1; the next-cycle re-check then sees the bubble and finds no hazard.
  - else all outputs 0.
- LOAD_STALL:
  - stall_o=1, bubble_o=1, flush_o=0.
  - cnt==0 → RUN; else cnt-1.
  - branch_taken_i here takes priority exactly as in RUN: flush, enter FLUSH, drop the stall.
- FLUSH:
  - flush_o=1, bubble_o=1, stall_o=0. Fetch proceeds from the redirected PC.
  - Hazard term is ignored.
  - cnt==0 → RUN; else cnt-1.
  - branch_taken_i here reloads cnt=FLUSH_CYCLES-1 and increments flush_count_o.
- Counters:
  - stall_count_o += 1 at each edge where stall_o==1.
  - flush_count_o += 1 at each edge where RUN, LOAD_STALL or FLUSH sees branch_taken_i.
  - Both saturate at all-ones and never wrap.
- Reset:
  - At the edge with reset_i=1: state=RUN, cnt=0, both counters=0.
  - While reset_i=1, stall_o, bubble_o and flush_o are forced to 0.
  - Reset mid-LOAD_STALL or mid-FLUSH abandons the sequence with no residual outputs.
- Addresses compare at full ADDR_WIDTH. No special register is excluded.

Decomposition:
- GENERAL_DEFS package holds:
  - ADDR_WIDTH and the mem_read_signal type (existing);
  - new enum hazard_state_t {RUN, LOAD_STALL, FLUSH}.
- One natural sub-module: sat_counter (parameter WIDTH; ports clk_i, reset_i, inc_i, count_o), instanced twice.

Test Plan:
- Load r3 in execute (ex_is_valid=1, mem read, dest=3); decode valid, uses_reg_1, source 1=3 → stall_o=1 and bubble_o=1 that cycle, 0 the next; stall_count_o=1.
- Same hazard with LOAD_LATENCY=3 → stall_o and bubble_o high exactly 3 cycles; stall_count_o=3.
- Non-load in execute with dest=3, or dec_uses_reg_1=0 → no stall; dest matches only source 2 with uses_reg_2=1 → stall.
- branch_taken_i and hazard in the same cycle → flush_o=1, stall_o=0, flush held FLUSH_CYCLES=2 cycles; flush_count_o=1, stall_count_o=0.
- reset_i asserted in the 2nd cycle of a LOAD_STALL=3 sequence → all outputs 0 during reset; state RUN and counters 0 after.
- Force 2^CNT_WIDTH+5 stall cycles (CNT_WIDTH=4) → stall_count_o holds at 15.
